// File: rtl/uart_rx_match.sv
// -----------------------------------------------------------------------------
// uart_rx_match
//
// 8N1 UART receiver with a "Hello World!" string detector.
//
// The serial line is double-flopped, then a five-state receive FSM samples
// each bit at its midpoint using a bit-period down-counter. A good stop bit
// publishes the byte. A low stop bit flags a framing error and waits in BREAK
// until the line returns high. Every published byte steps a 12-position
// matcher, which pulses `match` and bumps a saturating counter when the full
// greeting arrives back-to-back.
//
// Parameters
//   CLK_FREQ    system clock frequency in Hz
//   BAUD        serial bit rate; bit period = CLK_FREQ / BAUD clock cycles
//
// Ports
//   CLK         system clock, all state on the rising edge
//   rst_n       asynchronous active-low reset
//   PIN_1       raw UART RX line (idle high, LSB first), asynchronous to CLK
//   rx_byte     last correctly framed byte, held until the next good byte
//   rx_valid    one-cycle pulse; rx_byte shows the new byte in this cycle
//   frame_err   one-cycle pulse; the stop bit was sampled low
//   match       one-cycle pulse, the cycle after the closing "!" is accepted
//   match_count number of matches since reset, saturating at 255
//   busy        high whenever the receive FSM is not idle
// -----------------------------------------------------------------------------
module uart_rx_match #(
  parameter int CLK_FREQ = 12000000,
  parameter int BAUD     = 9600
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       PIN_1,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       match,
  output logic [7:0] match_count,
  output logic       busy
);

  localparam int BIT_CYC = CLK_FREQ / BAUD;
  localparam int CNT_W   = (BIT_CYC > 2) ? $clog2(BIT_CYC) : 1;

  // The first reload lands on the middle of the start bit. Each later reload
  // steps one full bit period, so every sample stays mid-bit.
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BIT_CYC / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BIT_CYC - 1);

  localparam logic [3:0] LAST_IDX = 4'd11;
  localparam logic [7:0] CHAR_H   = 8'h48;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  // Expected character at each matcher position.
  function automatic logic [7:0] greeting(input logic [3:0] idx);
    case (idx)
      4'd0:    greeting = 8'h48;  // H
      4'd1:    greeting = 8'h65;  // e
      4'd2:    greeting = 8'h6C;  // l
      4'd3:    greeting = 8'h6C;  // l
      4'd4:    greeting = 8'h6F;  // o
      4'd5:    greeting = 8'h20;  // space
      4'd6:    greeting = 8'h57;  // W
      4'd7:    greeting = 8'h6F;  // o
      4'd8:    greeting = 8'h72;  // r
      4'd9:    greeting = 8'h6C;  // l
      4'd10:   greeting = 8'h64;  // d
      default: greeting = 8'h21;  // !
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Input synchronizer. It resets to 1 (idle line), so reset release never
  // looks like a falling edge.
  // ---------------------------------------------------------------------------
  logic [1:0] sync_q;
  logic       line;

  // NOTE: clocked state uses non-blocking assignments, so every flop samples
  // the pre-edge value of the others (the two stages shift rather than collapse).
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], PIN_1};
    end
  end

  assign line = sync_q[1];

  // ---------------------------------------------------------------------------
  // Receive FSM: state register
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       data_q, data_d;
  logic             cnt_zero;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  assign cnt_zero = (cnt_q == '0);

  // ---------------------------------------------------------------------------
  // Receive FSM: next state and bit-timing datapath
  // ---------------------------------------------------------------------------
  // NOTE: each signal assigned in this block gets a hold value first. Any path
  // that skips an assignment then keeps the old value instead of inferring a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;

    case (state_q)
      S_IDLE: begin
        if (!line) begin
          state_d = S_START;
          cnt_d   = HALF_LOAD;
        end
      end

      S_START: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else if (line) begin
          // The line went back high before mid start bit: a glitch.
          state_d = S_IDLE;
        end else begin
          state_d = S_DATA;
          cnt_d   = FULL_LOAD;
          idx_d   = 3'd0;
        end
      end

      S_DATA: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          data_d[idx_q] = line;
          cnt_d         = FULL_LOAD;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end

      S_STOP: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = line ? S_IDLE : S_BREAK;
        end
      end

      S_BREAK: begin
        // Start detection stays off until the line has recovered.
        if (line) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Receive FSM: outputs
  // ---------------------------------------------------------------------------
  logic [7:0] rx_byte_q;

  always_comb begin
    rx_valid  = (state_q == S_STOP) && cnt_zero && line;
    frame_err = (state_q == S_STOP) && cnt_zero && !line;
    busy      = (state_q != S_IDLE);
    // The new byte is visible in the cycle rx_valid is high, then held.
    rx_byte   = rx_valid ? data_q : rx_byte_q;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      rx_byte_q <= 8'h00;
    end else if (rx_valid) begin
      rx_byte_q <= data_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Greeting matcher
  // Only a lone "H" restart is tracked on a mismatch. Longer overlapping
  // prefixes are deliberately not followed.
  // ---------------------------------------------------------------------------
  logic [3:0] m_q;
  logic       match_q;
  logic [7:0] count_q;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      m_q     <= '0;
      match_q <= 1'b0;
      count_q <= '0;
    end else begin
      match_q <= 1'b0;
      if (frame_err) begin
        m_q <= '0;
      end else if (rx_valid) begin
        if (data_q == greeting(m_q)) begin
          if (m_q == LAST_IDX) begin
            m_q     <= '0;
            match_q <= 1'b1;
            if (count_q != 8'hFF) begin
              count_q <= count_q + 8'd1;
            end
          end else begin
            m_q <= m_q + 4'd1;
          end
        end else if (data_q == CHAR_H) begin
          m_q <= 4'd1;
        end else begin
          m_q <= '0;
        end
      end
    end
  end

  assign match       = match_q;
  assign match_count = count_q;

endmodule
